// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive-side timing checker: coordinate recovery, lock, errors, frame stats
// Optional frame checksum enabled by defining VGA_RX_CHECKSUM_EN.
module vga_rx_monitor #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_ACT = 1'b0,
    parameter int   RGB_W    = 12,
    parameter int   X_POS_W  = 10,
    parameter int   Y_POS_W  = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pix_stb_i,
    input  logic               vga_hs_i,
    input  logic               vga_vs_i,
    input  logic [RGB_W-1:0]   vga_rgb_i,
    output logic [X_POS_W-1:0] x_o,
    output logic [Y_POS_W-1:0] y_o,
    output logic               active_o,
    output logic [RGB_W-1:0]   rgb_o,
    output logic               locked_o,
    output logic               frame_o,
    output logic               h_err_o,
    output logic               v_err_o,
    output logic [7:0]         err_cnt_o,
    output logic [15:0]        checksum_o,
    output logic               checksum_vld_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);
    localparam int H_OFF   = H_SYNC + H_BACK;
    localparam int V_OFF   = V_SYNC + V_BACK;

    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC - 1);
    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_WRAP     = HC_W'(H_TOTAL);
    localparam logic [HC_W-1:0] H_VIS_LO   = HC_W'(H_OFF);
    localparam logic [HC_W-1:0] H_VIS_HI   = HC_W'(H_OFF + H_ACTIVE);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_WRAP     = VC_W'(V_TOTAL);
    localparam logic [VC_W-1:0] V_VIS_LO   = VC_W'(V_OFF);
    localparam logic [VC_W-1:0] V_VIS_HI   = VC_W'(V_OFF + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t          state;
    logic            hs_prev, vs_prev, vs_pend;
    logic [HC_W-1:0] hcnt, h_next;
    logic [VC_W-1:0] vcnt, v_next;
    logic            hs_act, vs_act, hs_rise, hs_fall, vs_rise, vs_fall;
    logic            h_bad, v_bad, err, vis, lock_ok;

    always_comb begin
        hs_act  = (vga_hs_i == SYNC_ACT);
        vs_act  = (vga_vs_i == SYNC_ACT);
        hs_rise = hs_act & ~hs_prev;
        hs_fall = ~hs_act & hs_prev;
        vs_rise = vs_act & ~vs_prev;
        vs_fall = ~vs_act & vs_prev;
        h_next  = hs_rise ? '0 : hcnt + 1'b1;
        v_next  = vcnt;
        if (vs_rise)
            v_next = '0;
        else if (hs_rise)
            v_next = vcnt + 1'b1;
        // Counts below are those of the previous sample, i.e. the last pixel of the old phase.
        h_bad = (hs_fall && hcnt != H_SYNC_END) ||
                (hs_rise && hcnt != H_LAST) ||
                (!hs_rise && h_next == H_WRAP);
        v_bad = (hs_rise && (vs_pend || vs_fall) && v_next != V_SYNC_END) ||
                (vs_rise && vcnt != V_LAST) ||
                (hs_rise && !vs_rise && v_next == V_WRAP);
        err     = h_bad | v_bad;
        vis     = (h_next >= H_VIS_LO) && (h_next < H_VIS_HI) &&
                  (v_next >= V_VIS_LO) && (v_next < V_VIS_HI);
        lock_ok = (state == LOCKED) && !err;
    end

    assign locked_o = (state == LOCKED);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SEARCH;
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            vs_pend   <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
            x_o       <= '0;
            y_o       <= '0;
            active_o  <= 1'b0;
            rgb_o     <= '0;
            frame_o   <= 1'b0;
            h_err_o   <= 1'b0;
            v_err_o   <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            frame_o <= 1'b0;
            if (pix_stb_i) begin
                hs_prev  <= hs_act;
                vs_prev  <= vs_act;
                vs_pend  <= (vs_fall | vs_pend) & ~hs_rise & ~vs_rise;
                hcnt     <= (h_next == H_WRAP) ? '0 : h_next;
                vcnt     <= (v_next == V_WRAP) ? '0 : v_next;
                x_o      <= X_POS_W'(h_next - H_VIS_LO);
                y_o      <= Y_POS_W'(v_next - V_VIS_LO);
                rgb_o    <= vga_rgb_i;
                active_o <= vis && lock_ok;
                if (state != SEARCH) begin
                    h_err_o <= h_err_o | h_bad;
                    v_err_o <= v_err_o | v_bad;
                end
                case (state)
                    SEARCH: if (vs_rise) state <= TRACK;
                    TRACK: begin
                        if (err)
                            state <= SEARCH;
                        else if (vs_rise)
                            state <= LOCKED;
                    end
                    LOCKED: begin
                        if (err) begin
                            state <= SEARCH;
                            if (err_cnt_o != 8'hFF)
                                err_cnt_o <= err_cnt_o + 8'd1;
                        end else if (vs_rise) begin
                            frame_o <= 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] cs, pix16;

    assign pix16 = 16'(vga_rgb_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs             <= '0;
            checksum_o     <= '0;
            checksum_vld_o <= 1'b0;
        end else begin
            checksum_vld_o <= 1'b0;
            if (pix_stb_i) begin
                if (vs_rise)
                    cs <= '0;
                else if (vis && lock_ok)
                    cs <= {cs[14:0], cs[15]} ^ pix16;
                if (vs_rise && lock_ok) begin
                    checksum_o     <= cs;
                    checksum_vld_o <= 1'b1;
                end
            end
        end
    end
`else
    assign checksum_o     = 16'h0000;
    assign checksum_vld_o = 1'b0;
`endif

endmodule
